// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned ITER  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/shift_add_mult16_cla16b.sv
// CLA16b: 16-bit carry-lookahead adder built from four 4-bit lookahead groups
// with a second lookahead level across the group carries.
// Ports: X, Y (16b addends), Ci (carry-in) -> S (16b sum), Co (carry-out).
module CLA16b (
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic        Ci,
    output logic [15:0] S,
    output logic        Co
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;
    logic [15:0] c;

    assign g = X & Y;
    assign p = X ^ Y;

    // Group generate/propagate, group carries, then per-bit carries inside each group.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        for (int j = 0; j < 4; j++) begin
            grp_g[j] = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p[j] = &p[4*j +: 4];
        end
        grp_c[0] = Ci;
        grp_c[1] = grp_g[0] | (grp_p[0] & grp_c[0]);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & grp_c[0]);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
        grp_c[4] = grp_g[3] | (grp_p[3] & grp_c[3]);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = grp_c[j];
            c[4*j+1] = g[4*j] | (p[4*j] & grp_c[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & grp_c[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & grp_c[j]);
        end
    end

    assign S  = p ^ c;
    assign Co = grp_c[4];

endmodule

// File: rtl/shift_add_mult16.sv
// Sequential 16x16 -> 32-bit unsigned radix-2 shift-and-add multiplier.
// One CLA16b add per cycle; 16 iterations; start/ready/busy/done handshake.
// Ports: clk, rst (sync, active-high), start, a, b (operands, captured on accept),
//        ready (IDLE), busy (RUN), done (1-cycle pulse), product (32b, held).
module shift_add_mult16
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    mult_state_t        state_q;
    mult_state_t        state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   ph_q;
    logic [WIDTH-1:0]   pl_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   add_y;
    logic [WIDTH-1:0]   add_s;
    logic               add_co;
    logic [2*WIDTH-1:0] shifted;
    logic               last_iter;

    assign add_y     = pl_q[0] ? a_q : '0;
    // Carry-out lands in PH[15] after the shift, so the 33-bit sum is never truncated.
    assign shifted   = {add_co, add_s, pl_q[WIDTH-1:1]};
    assign last_iter = (cnt_q == CNT_W'(ITER - 1));

    CLA16b u_cla (
        .X  (ph_q),
        .Y  (add_y),
        .Ci (1'b0),
        .S  (add_s),
        .Co (add_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and the add/shift datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            ph_q      <= '0;
            pl_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        ph_q  <= '0;
                        pl_q  <= b;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    {ph_q, pl_q} <= shifted;
                    cnt_q        <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        product_q <= shifted;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult16.sv
// Directed and seeded-random checks for shift_add_mult16.
module tb_shift_add_mult16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int errors;
    int checks;
    bit inv_on;

    shift_add_mult16 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exactly one handshake flag every cycle once out of initial reset.
    always @(negedge clk) begin
        if (inv_on) check("onehot", 32'(ready) + 32'(busy) + 32'(done), 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply, check latency, product and return to ready.
    task automatic do_mult(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic [31:0] exp);
        int cyc;
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cyc   = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd16);
        check({tag, "_prod"}, product, exp);
        tick();
        check({tag, "_rdy"}, {31'd0, ready}, 32'd1);
        check({tag, "_hold"}, product, exp);
    endtask

    initial begin
        int dones;
        logic [15:0] ra;
        logic [15:0] rb;
        errors = 0;
        checks = 0;
        inv_on = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_prod", product, 32'd0);
        inv_on = 1'b1;

        do_mult("t1", 16'd3, 16'd5, 32'h0000_000F);
        do_mult("t2", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        do_mult("t3a", 16'h0000, 16'h1234, 32'd0);
        do_mult("t3b", 16'h1234, 16'h0000, 32'd0);
        do_mult("msb", 16'h8000, 16'h8000, 32'h4000_0000);

        // Start pulses while RUN and while in DONE must be ignored.
        a     = 16'd7;
        b     = 16'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            start = (cyc == 4 || cyc == 17);
            a     = start ? 16'd2 : 16'd0;
            b     = start ? 16'd2 : 16'd0;
            tick();
            if (done) begin
                dones++;
                check("t4_prod", product, 32'd63);
            end
        end
        start = 1'b0;
        check("t4_dones", 32'(dones), 32'd1);
        check("t4_ready", {31'd0, ready}, 32'd1);
        check("t4_hold", product, 32'd63);

        // Reset mid-run aborts and clears the product.
        a     = 16'd100;
        b     = 16'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_ready", {31'd0, ready}, 32'd1);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_prod", product, 32'd0);
        do_mult("t5", 16'd100, 16'd200, 32'd20000);

        // Reset beats start in the same cycle.
        a     = 16'd5;
        b     = 16'd5;
        start = 1'b1;
        rst   = 1'b1;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        check("t6_ready", {31'd0, ready}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_prod", product, 32'd0);
        tick();
        check("t6_idle", {31'd0, ready}, 32'd1);

        // Random operands against a reference product.
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_mult("rnd", ra, rb, 32'(ra) * 32'(rb));
        end

        inv_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
